gpio_in_filter: RTL and testbench
=================================

// Module: gpio_in_filter
//
// PURPOSE
//   Input conditioning stage for the GPIO port. Sits downstream of the pad
//   tri-state buffers and feeds the SoC GPIO peripheral. Per bit: synchronises
//   raw pad levels into CLK, optionally debounces them and detects
//   rising/falling edges. Edges set sticky interrupt status, summarised on IRQ.
//
// PARAMETERS
//   WIDTH           8   number of GPIO bits
//   SYNC_STAGES     2   synchroniser flops per bit, >=2
//   DEBOUNCE_CYCLES 16  stable cycles before a debounced bit updates, >=1
//
// PORTS
//   CLK         in   1      system clock (hclk domain)
//   PORESETn    in   1      async active-low reset, all state cleared
//   GPIO_I      in   WIDTH  raw pad levels, asynchronous to CLK
//   DEB_EN      in   WIDTH  per-bit debounce enable; 0 = bypass counter
//   RISE_EN     in   WIDTH  per-bit rising-edge event enable
//   FALL_EN     in   WIDTH  per-bit falling-edge event enable
//   IRQ_CLR     in   WIDTH  per-bit status clear, 1-cycle pulse
//   GPIO_VAL    out  WIDTH  filtered level, registered
//   IRQ_STATUS  out  WIDTH  sticky edge-event flags, registered
//   IRQ         out  1      OR-reduce of IRQ_STATUS
//
// BEHAVIOUR
//   Reset: all sync flops, counters, GPIO_VAL and IRQ_STATUS go to 0
//     asynchronously. IRQ reads 0.
//   Sync: s = last stage of SYNC_STAGES flop chain per bit. No logic before
//     the chain.
//   Filter, per bit, each CLK edge:
//     DEB_EN=0: GPIO_VAL <= s; cnt <= 0.
//     DEB_EN=1, s==GPIO_VAL: cnt <= 0. A glitch restarts the count.
//     DEB_EN=1, s!=GPIO_VAL, cnt==DEBOUNCE_CYCLES-1: GPIO_VAL <= s; cnt <= 0.
//     DEB_EN=1, s!=GPIO_VAL, otherwise: cnt <= cnt+1.
//     Counter width: max(1,$clog2(DEBOUNCE_CYCLES)). It never wraps.
//   Latency: the pad changes before edge 1.
//     Bypass mode: GPIO_VAL updates at edge SYNC_STAGES+1.
//     Debounce mode: GPIO_VAL updates at edge SYNC_STAGES+DEBOUNCE_CYCLES,
//     provided s stays stable.
//   DEB_EN 1->0 mid-count: cnt clears. GPIO_VAL follows s on that edge.
//   Events: a bit's event fires on the same edge its GPIO_VAL updates.
//     Rise event: GPIO_VAL 0->1 and RISE_EN=1.
//     Fall event: GPIO_VAL 1->0 and FALL_EN=1.
//     On an event, IRQ_STATUS bit <= 1.
//   Clear: with IRQ_CLR=1 and no event, IRQ_STATUS bit <= 0 on the next edge.
//     Event and IRQ_CLR on the same edge: set wins, bit stays 1.
//   Enable changes never create events retroactively. Only GPIO_VAL
//     transitions do.
//   IRQ is combinational OR of IRQ_STATUS flops. It updates in the same cycle
//     as IRQ_STATUS.
//   Post-reset: GPIO_VAL resets to 0. A pad held high after release produces
//     a 0->1 transition, which raises an event if RISE_EN=1. Software keeps
//     RISE_EN=0 until init completes.
//   Reset mid-operation: count and pending level are discarded. Filtering
//     restarts from 0 after PORESETn deasserts.
//
// TESTING
//   1 DEB_EN=0, RISE_EN[0]=1, GPIO_I[0] 0->1 before edge 1
//     -> GPIO_VAL[0]=1 and IRQ_STATUS[0]=1 after edge 3; IRQ=1.
//   2 DEB_EN[1]=1, high pulse of 10 cycles on GPIO_I[1]
//     -> GPIO_VAL[1] stays 0, no event.
//     Hold high 20 cycles -> GPIO_VAL[1]=1 exactly at edge 18.
//   3 GPIO_I[2] with DEB_EN: high 15 cycles, low 1, high 16
//     -> single update at the end of the second 16-cycle run.
//   4 GPIO_VAL[3] rises with RISE_EN=1 while IRQ_CLR[3]=1 on that edge
//     -> status stays 1. Next IRQ_CLR[3] alone -> status 0, IRQ 0.
//   5 RISE_EN[7]=0, FALL_EN[7]=1, bypass, pulse GPIO_I[7] 0->1->0
//     -> only falling edge sets IRQ_STATUS[7].
//   6 PORESETn low at cnt=8
//     -> outputs 0 immediately. After release, a full SYNC_STAGES+16 edges
//     are needed to update.

Source files
------------

// File: rtl/gpio_in_filter_if.sv
// Signal bundle between the GPIO pad conditioning stage and the GPIO peripheral.
// Valid/ready handshakes are absent: every field is a level, sampled on each CLK edge.
interface gpio_in_filter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] GPIO_I;
  logic [WIDTH-1:0] DEB_EN;
  logic [WIDTH-1:0] RISE_EN;
  logic [WIDTH-1:0] FALL_EN;
  logic [WIDTH-1:0] IRQ_CLR;
  logic [WIDTH-1:0] GPIO_VAL;
  logic [WIDTH-1:0] IRQ_STATUS;
  logic             IRQ;

  modport master (
    output GPIO_I, DEB_EN, RISE_EN, FALL_EN, IRQ_CLR,
    input  GPIO_VAL, IRQ_STATUS, IRQ
  );

  modport slave (
    input  GPIO_I, DEB_EN, RISE_EN, FALL_EN, IRQ_CLR,
    output GPIO_VAL, IRQ_STATUS, IRQ
  );
endinterface

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-bit synchroniser, optional debounce counter,
// rising/falling edge detection into sticky interrupt status with an OR summary.
module gpio_in_filter #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic          CLK,
    input logic          PORESETn,
    gpio_in_filter_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_evt;

    // Pad levels enter the chain directly so only flops see the async input.
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.GPIO_I;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synchronised level disagrees with the
    // filtered level; any agreement, including a glitch back, restarts it.
    always_comb begin
        val_d = val_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!bus.DEB_EN[i]) begin
                val_d[i] = sync_s[i];
            end else if (sync_s[i] != val_q[i]) begin
                if (cnt_q[i] == CNT_MAX) val_d[i] = sync_s[i];
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign edge_evt = ( val_d & ~val_q & bus.RISE_EN)
                    | (~val_d &  val_q & bus.FALL_EN);

    // Set has priority over clear when both land on the same edge.
    assign status_d = edge_evt | (status_q & ~bus.IRQ_CLR);

    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            val_q    <= '0;
            status_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            val_q    <= val_d;
            status_q <= status_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.GPIO_VAL   = val_q;
    assign bus.IRQ_STATUS = status_q;
    assign bus.IRQ        = |status_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: latency, debounce, edge events, clear priority, reset.
module tb_gpio_in_filter;

  logic CLK;
  logic PORESETn;
  int   tests_run;
  int   tests_failed;

  gpio_in_filter_if #(.WIDTH(8)) bus ();

  gpio_in_filter #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .PORESETn(PORESETn),
    .bus(bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1, "timeout");
  end

  // advance one active edge, then settle for sampling
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // quiet all inputs, let pipeline drain to 0, wipe status
  task automatic setup();
    bus.GPIO_I  = '0;
    bus.DEB_EN  = '0;
    bus.RISE_EN = '0;
    bus.FALL_EN = '0;
    bus.IRQ_CLR = '0;
    repeat (4) step();
    bus.IRQ_CLR = '1;
    step();
    bus.IRQ_CLR = '0;
  endtask

  task automatic test_reset();
    PORESETn = 1'b0;
    bus.GPIO_I  = 8'hff;
    bus.DEB_EN  = '0;
    bus.RISE_EN = '1;
    bus.FALL_EN = '1;
    bus.IRQ_CLR = '0;
    repeat (3) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h00 || bus.IRQ_STATUS !== 8'h00 || bus.IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: val=%h status=%h irq=%b required 00 00 0",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
    bus.GPIO_I  = '0;
    bus.RISE_EN = '0;
    bus.FALL_EN = '0;
    PORESETn = 1'b1;
    step();
  endtask

  task automatic test_bypass_rise();
    setup();
    bus.RISE_EN = 8'h01;
    bus.GPIO_I  = 8'h01;
    repeat (2) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h00) begin
      tests_failed++;
      $display("FAIL bypass_edge2: val=%h required 00", bus.GPIO_VAL);
    end
    step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h01 || bus.IRQ_STATUS !== 8'h01 || bus.IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_edge3: val=%h status=%h irq=%b required 01 01 1",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
    bus.IRQ_CLR = 8'h01;
    step();
    bus.IRQ_CLR = 8'h00;
    tests_run++;
    if (bus.IRQ_STATUS !== 8'h00 || bus.IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_clear: status=%h irq=%b required 00 0", bus.IRQ_STATUS, bus.IRQ);
    end
  endtask

  task automatic test_debounce_pulse();
    setup();
    bus.DEB_EN  = 8'h02;
    bus.RISE_EN = 8'h02;
    bus.GPIO_I  = 8'h02;
    for (int e = 1; e <= 30; e++) begin
      if (e == 11) bus.GPIO_I = 8'h00;
      step();
      tests_run++;
      if (bus.GPIO_VAL !== 8'h00 || bus.IRQ_STATUS !== 8'h00) begin
        tests_failed++;
        $display("FAIL deb_short_pulse e%0d: val=%h status=%h required 00 00",
                 e, bus.GPIO_VAL, bus.IRQ_STATUS);
      end
    end
    bus.GPIO_I = 8'h02;
    repeat (17) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h00) begin
      tests_failed++;
      $display("FAIL deb_edge17: val=%h required 00", bus.GPIO_VAL);
    end
    step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h02 || bus.IRQ_STATUS !== 8'h02 || bus.IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL deb_edge18: val=%h status=%h irq=%b required 02 02 1",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
  endtask

  // high 15, low 1, high onward: the dip restarts the count
  task automatic test_debounce_glitch();
    logic [7:0] exp_val;
    setup();
    bus.DEB_EN  = 8'h04;
    bus.RISE_EN = 8'h04;
    for (int e = 1; e <= 38; e++) begin
      bus.GPIO_I = (e == 16) ? 8'h00 : 8'h04;
      step();
      exp_val = (e >= 34) ? 8'h04 : 8'h00;
      tests_run++;
      if (bus.GPIO_VAL !== exp_val) begin
        tests_failed++;
        $display("FAIL deb_glitch e%0d: val=%h required %h", e, bus.GPIO_VAL, exp_val);
      end
    end
    tests_run++;
    if (bus.IRQ_STATUS !== 8'h04) begin
      tests_failed++;
      $display("FAIL deb_glitch_status: status=%h required 04", bus.IRQ_STATUS);
    end
  endtask

  task automatic test_set_beats_clear();
    setup();
    bus.RISE_EN = 8'h08;
    bus.GPIO_I  = 8'h08;
    repeat (2) step();
    bus.IRQ_CLR = 8'h08;
    step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h08 || bus.IRQ_STATUS !== 8'h08 || bus.IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_wins: val=%h status=%h irq=%b required 08 08 1",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
    step();
    bus.IRQ_CLR = 8'h00;
    tests_run++;
    if (bus.IRQ_STATUS !== 8'h00 || bus.IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_alone: status=%h irq=%b required 00 0", bus.IRQ_STATUS, bus.IRQ);
    end
  endtask

  task automatic test_fall_only();
    setup();
    bus.FALL_EN = 8'h80;
    bus.GPIO_I  = 8'h80;
    step();
    bus.GPIO_I  = 8'h00;
    repeat (2) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h80 || bus.IRQ_STATUS !== 8'h00) begin
      tests_failed++;
      $display("FAIL fall_only_rise: val=%h status=%h required 80 00",
               bus.GPIO_VAL, bus.IRQ_STATUS);
    end
    step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h00 || bus.IRQ_STATUS !== 8'h80 || bus.IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL fall_only_fall: val=%h status=%h irq=%b required 00 80 1",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
  endtask

  task automatic test_reset_mid_count();
    setup();
    bus.DEB_EN  = 8'h10;
    bus.RISE_EN = 8'h20;
    bus.GPIO_I  = 8'h30;
    repeat (10) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h20 || bus.IRQ_STATUS !== 8'h20) begin
      tests_failed++;
      $display("FAIL pre_reset: val=%h status=%h required 20 20", bus.GPIO_VAL, bus.IRQ_STATUS);
    end
    #2;
    PORESETn = 1'b0;
    #1;
    tests_run++;
    if (bus.GPIO_VAL !== 8'h00 || bus.IRQ_STATUS !== 8'h00 || bus.IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: val=%h status=%h irq=%b required 00 00 0",
               bus.GPIO_VAL, bus.IRQ_STATUS, bus.IRQ);
    end
    repeat (2) step();
    PORESETn = 1'b1;
    repeat (17) step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h20 || bus.IRQ_STATUS !== 8'h20) begin
      tests_failed++;
      $display("FAIL post_reset_e17: val=%h status=%h required 20 20",
               bus.GPIO_VAL, bus.IRQ_STATUS);
    end
    step();
    tests_run++;
    if (bus.GPIO_VAL !== 8'h30 || bus.IRQ_STATUS !== 8'h20) begin
      tests_failed++;
      $display("FAIL post_reset_e18: val=%h status=%h required 30 20",
               bus.GPIO_VAL, bus.IRQ_STATUS);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_bypass_rise();
    test_debounce_pulse();
    test_debounce_glitch();
    test_set_beats_clear();
    test_fall_only();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
